// File: rtl/irda_mode_sequencer_if.sv
// rtl/irda_mode_sequencer_if.sv - request, busy and applied-config signals between register, sequencer and datapaths
interface irda_mode_sequencer_if;
  logic       req_tx_select;
  logic [1:0] req_speed;
  logic       req_loopback;
  logic       tx_busy;
  logic       rx_busy;
  logic       cur_tx_select;
  logic [1:0] cur_speed;
  logic       cur_loopback;
  logic       tx_enable;
  logic       rx_enable;
  logic       mode_busy;
  logic       change_done;
  logic       drain_abort;

  modport master (
    output req_tx_select, req_speed, req_loopback, tx_busy, rx_busy,
    input  cur_tx_select, cur_speed, cur_loopback, tx_enable, rx_enable,
           mode_busy, change_done, drain_abort
  );

  modport slave (
    input  req_tx_select, req_speed, req_loopback, tx_busy, rx_busy,
    output cur_tx_select, cur_speed, cur_loopback, tx_enable, rx_enable,
           mode_busy, change_done, drain_abort
  );
endinterface

// File: rtl/irda_mode_sequencer.sv
// rtl/irda_mode_sequencer.sv - drains, quiets and atomically applies IrDA link configuration changes
module irda_mode_sequencer #(
  parameter int TURNAROUND_CYCLES = 16,
  parameter int DRAIN_TIMEOUT     = 1024,
  parameter int CNT_W             = 11
) (
  input logic                  clk,
  input logic                  wb_rst_n,
  irda_mode_sequencer_if.slave bus
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_QUIET  = 2'd2;
  localparam logic [1:0] ST_APPLY  = 2'd3;

  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cur_tx_select;
  logic [1:0]       cur_speed;
  logic             cur_loopback;
  logic             tx_enable;
  logic             rx_enable;
  logic             mode_busy;
  logic             change_done;
  logic             drain_abort;

  logic [3:0] req_cfg;
  logic [3:0] cur_cfg;
  logic       mismatch;
  logic       monitored_busy;

  assign req_cfg  = {bus.req_tx_select, bus.req_speed, bus.req_loopback};
  assign cur_cfg  = {cur_tx_select, cur_speed, cur_loopback};
  assign mismatch = (req_cfg != cur_cfg);

  // Only the direction currently carrying traffic can hold off the change.
  assign monitored_busy = cur_tx_select ? bus.tx_busy : bus.rx_busy;

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state         <= ST_ACTIVE;
      cnt           <= '0;
      cur_tx_select <= 1'b0;
      cur_speed     <= 2'b00;
      cur_loopback  <= 1'b0;
      tx_enable     <= 1'b0;
      rx_enable     <= 1'b1;
      mode_busy     <= 1'b0;
      change_done   <= 1'b0;
      drain_abort   <= 1'b0;
    end else begin
      change_done <= 1'b0;
      drain_abort <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (mismatch) begin
            state     <= ST_DRAIN;
            mode_busy <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_DRAIN: begin
          if (!monitored_busy || cnt == DRAIN_LAST) begin
            state       <= ST_QUIET;
            tx_enable   <= 1'b0;
            rx_enable   <= 1'b0;
            cnt         <= QUIET_LOAD;
            drain_abort <= monitored_busy;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_QUIET: begin
          if (cnt == '0) begin
            state <= ST_APPLY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // The request is sampled here, so late edits during the gap win.
          cur_tx_select <= bus.req_tx_select;
          cur_speed     <= bus.req_speed;
          cur_loopback  <= bus.req_loopback;
          tx_enable     <= bus.req_tx_select;
          rx_enable     <= ~bus.req_tx_select | bus.req_loopback;
          mode_busy     <= 1'b0;
          change_done   <= 1'b1;
          state         <= ST_ACTIVE;
        end
      endcase
    end
  end

  assign bus.cur_tx_select = cur_tx_select;
  assign bus.cur_speed     = cur_speed;
  assign bus.cur_loopback  = cur_loopback;
  assign bus.tx_enable     = tx_enable;
  assign bus.rx_enable     = rx_enable;
  assign bus.mode_busy     = mode_busy;
  assign bus.change_done   = change_done;
  assign bus.drain_abort   = drain_abort;

endmodule

// File: tb/tb_irda_mode_sequencer.sv
// tb/tb_irda_mode_sequencer.sv - directed and randomized checks against an edge-timestamp reference model
module tb_irda_mode_sequencer;
  localparam int T  = 16;
  localparam int DT = 1024;

  logic clk = 1'b0;
  logic wb_rst_n = 1'b0;
  always #5 clk = ~clk;

  irda_mode_sequencer_if bus();

  irda_mode_sequencer #(
    .TURNAROUND_CYCLES(T),
    .DRAIN_TIMEOUT(DT),
    .CNT_W(11)
  ) dut (
    .clk(clk),
    .wb_rst_n(wb_rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  // Reference: the change is described by the edge it was seen (t0), the edge
  // the drain finished (de), and the apply edge de+T+1.
  int         n;
  bit         in_seq;
  bit         drained;
  int         t0;
  int         de;
  logic [3:0] m_cur;
  logic       m_done;
  logic       m_abort;

  function automatic logic [3:0] req_now();
    return {bus.req_tx_select, bus.req_speed, bus.req_loopback};
  endfunction

  task automatic model_reset();
    n = 0; in_seq = 0; drained = 0; t0 = 0; de = 0;
    m_cur = 4'h0; m_done = 0; m_abort = 0;
  endtask

  task automatic model_step();
    logic mon;
    n++;
    m_done = 0;
    m_abort = 0;
    if (!in_seq) begin
      if (req_now() != m_cur) begin
        in_seq = 1; drained = 0; t0 = n;
      end
    end else if (!drained) begin
      mon = m_cur[3] ? bus.tx_busy : bus.rx_busy;
      if (!mon || (n - t0) == DT) begin
        drained = 1; de = n; m_abort = mon;
      end
    end else if (n == de + T + 1) begin
      m_cur = req_now(); m_done = 1; in_seq = 0;
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.cur_tx_select, bus.cur_speed, bus.cur_loopback, bus.tx_enable,
            bus.rx_enable, bus.mode_busy, bus.change_done, bus.drain_abort};
  endfunction

  function automatic logic [8:0] expv();
    logic gap;
    gap = in_seq && drained;
    return {m_cur, gap ? 1'b0 : m_cur[3], gap ? 1'b0 : (~m_cur[3] | m_cur[0]),
            in_seq, m_done, m_abort};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", 32'(outs()), 32'(expv()));
    if (bus.change_done) done_cnt++;
    if (bus.drain_abort) abort_cnt++;
  endtask

  task automatic set_req(input logic [3:0] r);
    {bus.req_tx_select, bus.req_speed, bus.req_loopback} = r;
  endtask

  initial begin
    int k_done;
    int k_abort;
    int d0;
    set_req(4'h0);
    bus.tx_busy = 0;
    bus.rx_busy = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'(9'b0_00_0_0_1_0_0_0));
    @(negedge clk);
    wb_rst_n = 1'b1;

    // Idle hold at the reset configuration.
    repeat (50) tick();
    chk("idle_outs", 32'(outs()), 32'(9'b0_00_0_0_1_0_0_0));
    chk("idle_pulses", 32'(done_cnt + abort_cnt), 0);

    // RX/SIR -> TX/FIR with both paths idle.
    set_req(4'b1_01_0);
    d0 = done_cnt;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 2 && k <= 18) chk("s2_gap_enables", 32'({bus.tx_enable, bus.rx_enable}), 0);
      if (k == 19) chk("s2_applied", 32'(outs()), 32'(9'b1_01_0_1_0_0_1_0));
      if (k == 20) chk("s2_done_drop", 32'(bus.change_done), 0);
    end
    chk("s2_done_count", 32'(done_cnt - d0), 1);

    // TX drains a 40-cycle frame before switching to RX.
    bus.tx_busy = 1;
    set_req(4'b0_01_0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("s3_tx_held", 32'(bus.tx_enable), 1);
    end
    bus.tx_busy = 0;
    k_done = -1;
    d0 = abort_cnt;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.change_done && k_done < 0) k_done = k;
    end
    chk("s3_done_edge", 32'(k_done), 18);
    chk("s3_no_abort", 32'(abort_cnt - d0), 0);

    // RX busy stuck high: the drain times out and cuts the frame.
    bus.rx_busy = 1;
    set_req(4'b1_01_0);
    k_done = -1;
    k_abort = -1;
    d0 = abort_cnt;
    for (int k = 1; k <= 1060; k++) begin
      tick();
      if (bus.drain_abort && k_abort < 0) k_abort = k;
      if (bus.change_done && k_done < 0) k_done = k;
    end
    bus.rx_busy = 0;
    chk("s4_abort_edge", 32'(k_abort), 1025);
    chk("s4_abort_count", 32'(abort_cnt - d0), 1);
    chk("s4_done_edge", 32'(k_done), 1042);
    chk("s4_applied", 32'({bus.cur_tx_select, bus.tx_enable, bus.rx_enable}), 32'(3'b110));

    // Latest request wins when edited during the quiet gap.
    set_req(4'b1_10_0);
    repeat (6) tick();
    set_req(4'b1_11_0);
    d0 = done_cnt;
    repeat (30) tick();
    chk("s5_single_done", 32'(done_cnt - d0), 1);
    chk("s5_speed", 32'(bus.cur_speed), 32'(2'b11));

    // Reverting during the gap still produces a change_done, config unchanged.
    set_req(4'b1_00_0);
    repeat (6) tick();
    set_req(4'b1_11_0);
    d0 = done_cnt;
    repeat (30) tick();
    chk("s6_revert_done", 32'(done_cnt - d0), 1);
    chk("s6_revert_cfg", 32'({bus.cur_tx_select, bus.cur_speed, bus.cur_loopback}), 32'(4'b1_11_0));

    // Reset in the middle of the quiet gap.
    set_req(4'b0_10_1);
    repeat (6) tick();
    d0 = done_cnt;
    wb_rst_n = 1'b0;
    model_reset();
    #1;
    chk("s7_reset_outs", 32'(outs()), 32'(9'b0_00_0_0_1_0_0_0));
    @(negedge clk);
    chk("s7_reset_hold", 32'(outs()), 32'(9'b0_00_0_0_1_0_0_0));
    wb_rst_n = 1'b1;
    tick();
    chk("s7_restart_busy", 32'(bus.mode_busy), 1);
    repeat (25) tick();
    chk("s7_applied", 32'({bus.cur_tx_select, bus.cur_speed, bus.cur_loopback, bus.rx_enable}),
        32'(5'b0_10_1_1));
    chk("s7_one_done", 32'(done_cnt - d0), 1);

    // Randomized requests and busy traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) set_req(4'($urandom));
      if ($urandom_range(0, 3) == 0) bus.tx_busy = ~bus.tx_busy;
      if ($urandom_range(0, 3) == 0) bus.rx_busy = ~bus.rx_busy;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
